// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Defining SUB_SERIAL_DECOY_EN adds the PRE/POST pass-through and decoy states.
package sub_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

`ifdef SUB_SERIAL_DECOY_EN
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        DONE = 3'd2,
        PRE  = 3'd3,
        POST = 3'd4,
        DEC0 = 3'd6,
        DEC1 = 3'd7
    } state_e;
`else
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;
`endif

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_bit_sub.sv
// One-bit full subtractor cell: computes x + ~y + cin.
module serial_bit_sub
    import sub_serial_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic d,
    output logic cout
);

    assign d    = x ^ ~y ^ cin;
    assign cout = maj3(x, ~y, cin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor (out = a - b mod 2^WIDTH, LSB first) with IDLE/SUB/DONE handshake.
// Defining SUB_SERIAL_DECOY_EN inserts PRE/POST states and unreachable decoy states.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_r, state_s;
    logic [WIDTH-1:0]   a_r, a_s, b_r, b_s, out_r, out_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic               carry_r, carry_s, borrow_r, borrow_s;
    logic               d_s, cout_s;

    serial_bit_sub u_bit (
        .x    (a_r[0]),
        .y    (b_r[0]),
        .cin  (carry_r),
        .d    (d_s),
        .cout (cout_s)
    );

    assign out    = out_r;
    assign borrow = borrow_r;
    assign done   = (state_r == DONE);

    // Next-state and next-datapath logic; every register holds unless its state updates it.
    always_comb begin
        state_s  = state_r;
        a_s      = a_r;
        b_s      = b_r;
        out_s    = out_r;
        count_s  = count_r;
        carry_s  = carry_r;
        borrow_s = borrow_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    a_s      = a;
                    b_s      = b;
                    out_s    = {WIDTH{1'b0}};
                    count_s  = {CNT_W{1'b0}};
                    carry_s  = 1'b1;
                    borrow_s = 1'b0;
`ifdef SUB_SERIAL_DECOY_EN
                    state_s  = PRE;
`else
                    state_s  = SUB;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SUB: begin
                out_s   = {d_s, out_r[WIDTH-1:1]};
                carry_s = cout_s;
                a_s     = {1'b0, a_r[WIDTH-1:1]};
                b_s     = {1'b0, b_r[WIDTH-1:1]};
                count_s = count_r + CNT_W'(1);
                if (count_r == LAST_CNT) begin
                    // Final carry of a + ~b + 1 is the inverted borrow.
                    borrow_s = ~cout_s;
`ifdef SUB_SERIAL_DECOY_EN
                    state_s  = POST;
`else
                    state_s  = DONE;
`endif
                end else begin
                    state_s = SUB;
                end
            end
            DONE: begin
                if (en) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
`ifdef SUB_SERIAL_DECOY_EN
            PRE:  state_s = SUB;
            POST: state_s = DONE;
            DEC0: begin
                a_s     = {a_r[WIDTH-2:0], 1'b0};
                carry_s = a_r[0] | b_r[0] | carry_r;
                state_s = DEC1;
            end
            DEC1: begin
                out_s   = {out_r[WIDTH-2:0], d_s};
                count_s = count_r - CNT_W'(1);
                state_s = DEC0;
            end
`endif
            default: state_s = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            out_r    <= {WIDTH{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            carry_r  <= 1'b0;
            borrow_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            a_r      <= a_s;
            b_r      <= b_s;
            out_r    <= out_s;
            count_r  <= count_s;
            carry_r  <= carry_s;
            borrow_r <= borrow_s;
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Directed and random bench for sub_serial against an arithmetic reference model.
module tb_sub_serial;

    localparam int WIDTH = 8;
`ifdef SUB_SERIAL_DECOY_EN
    localparam int LAT = WIDTH + 2;
`else
    localparam int LAT = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic [WIDTH-1:0] a   = '0;
    logic [WIDTH-1:0] b   = '0;
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             done;

    int               n_assert = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] exp_out;
    logic             exp_borrow;

    sub_serial #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .b      (b),
        .out    (out),
        .borrow (borrow),
        .done   (done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Starts at a negedge; returns at the negedge where done must have just risen.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic hold_en, input logic scramble);
        int unsigned diff;
        diff       = (int'(av) - int'(bv)) & ((1 << WIDTH) - 1);
        exp_out    = diff[WIDTH-1:0];
        exp_borrow = (av < bv);
        a  = av;
        b  = bv;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = hold_en;
        if (scramble) begin
            a = 8'hAA;
            b = 8'h55;
        end else begin
            a = $urandom;
            b = $urandom;
        end
        for (int i = 0; i < LAT; i++) begin
            check("done_low_during_op", done, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        check("done_high", done, 1'b1);
        check("out", out, exp_out);
        check("borrow", borrow, exp_borrow);
    endtask

    // From DONE: hold one cycle with en=0, then acknowledge back to IDLE.
    task automatic finish_op();
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_hold", done, 1'b1);
        check("out_hold", out, exp_out);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_cleared", done, 1'b0);
        en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check("rst_out", out, 8'h00);
        check("rst_borrow", borrow, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_no_start", done, 1'b0);

        run_op(8'd100, 8'd37, 1'b0, 1'b0);
        check("t1_const", out, 8'h3F);
        finish_op();
        run_op(8'd5, 8'd9, 1'b0, 1'b0);
        check("t2_const", out, 8'hFC);
        finish_op();
        run_op(8'h00, 8'hFF, 1'b0, 1'b0);
        finish_op();
        run_op(8'h00, 8'h00, 1'b0, 1'b0);
        finish_op();
        run_op(8'hFF, 8'h00, 1'b0, 1'b0);
        finish_op();

        // en held high through the operation while operands change.
        run_op(8'h3C, 8'hC3, 1'b1, 1'b1);
        finish_op();

        // Asynchronous reset in the 4th SUB cycle.
        a  = 8'h77;
        b  = 8'h11;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_out", out, 8'h00);
        check("async_rst_borrow", borrow, 1'b0);
        check("async_rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("after_rst_idle", done, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 1'b0);
        finish_op();

        for (int k = 0; k < 12; k++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
            finish_op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
